enigma_key_entry: RTL

Upstream input stage for the `enigma` core on the DE2 board. It conditions the raw active-low push-button (`KEY[3]`) and the switch-selected character (`SW[7:0]`) into a clean, single-cycle `char_pressed` strobe with a stable, range-checked character. This keeps mechanical bounce from stepping the rotors more than once per keypress.

---
 rtl/enigma_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/enigma_key_entry.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared constants and types for the enigma datapath and its key-entry front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package enigma_pkg;

    // Rotor alphabet: characters 0..ALPHABET_SIZE-1 are legal key codes.
    localparam int ALPHABET_SIZE = 26;

    // Width of a character code as carried on the board switches.
    localparam int CHAR_W = 8;

    typedef logic [CHAR_W-1:0] char_t;

    // Key-entry debounce FSM.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_t;

    // True when the character code lies inside the rotor alphabet.
    function automatic logic char_in_range(input char_t c);
        return c < CHAR_W'(ALPHABET_SIZE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, with a configurable reset value.
// Latency: 2 cycles from input change to output change.
// Backpressure: none; a level follower.
module sync_2ff
    import enigma_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages load the reset value so the output is defined at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/enigma_key_entry.sv
// Debounces KEY[3] and range-checks SW[7:0], emitting one char_pressed/char_error strobe per press.
// Latency: DEBOUNCE_CYCLES+3 cycles from first low sample to strobe; optional auto-repeat via ENIGMA_AUTO_REPEAT_EN.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module enigma_key_entry
    import enigma_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              key_n,
    input  logic [CHAR_W-1:0] char_raw,
    output logic              char_pressed,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_error,
    output logic              key_held
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // A one-cycle debounce window cannot reject any bounce, and zero-length repeat intervals are meaningless.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("enigma_key_entry: DEBOUNCE_CYCLES must be >= 2 and repeat intervals non-zero");
    end

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic  key_n_sync;
    char_t char_sync;

    // Key resets to released so a reset never looks like a press edge.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_key_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     (key_n),
        .q     (key_n_sync)
    );

    sync_2ff #(
        .WIDTH     (CHAR_W),
        .RESET_VAL ({CHAR_W{1'b0}})
    ) u_char_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     (char_raw),
        .q     (char_sync)
    );

    logic key_down;
    assign key_down = ~key_n_sync;

    // ------------------------------------------------------------------
    // Debounce: the level must disagree for DEBOUNCE_CYCLES straight cycles
    // ------------------------------------------------------------------
    logic            deb_pressed;
    logic [DB_W-1:0] db_cnt;
    logic            level_differs;

    assign level_differs = (key_down != deb_pressed);

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the window.
    // The counter stops at DB_LAST and clears on the flip, so it can never wrap.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            db_cnt      <= '0;
            deb_pressed <= 1'b0;
        end else if (!level_differs) begin
            db_cnt      <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt      <= '0;
            deb_pressed <= ~deb_pressed;
        end else begin
            db_cnt      <= db_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Press/release FSM
    // ------------------------------------------------------------------
    key_state_t state;
    key_state_t next_state;
    logic       press_accept;
    logic       rpt_hit;
    logic       fire;
    logic       sample_ok;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= RELEASED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a completed debounce wins over a bounce seen in the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            RELEASED: begin
                if (key_down) begin
                    next_state = PRESS_PEND;
                end
            end
            PRESS_PEND: begin
                if (deb_pressed) begin
                    next_state = HELD;
                end else if (!key_down) begin
                    next_state = RELEASED;
                end
            end
            HELD: begin
                if (!key_down) begin
                    next_state = RELEASE_PEND;
                end
            end
            RELEASE_PEND: begin
                if (!deb_pressed) begin
                    next_state = RELEASED;
                end else if (key_down) begin
                    next_state = HELD;
                end
            end
            default: begin
                next_state = RELEASED;
            end
        endcase
    end

    // Decode strobe requests: accepted press, or a repeat tick while held.
    always_comb begin
        press_accept = (state == PRESS_PEND) && deb_pressed;
        fire         = press_accept || rpt_hit;
        sample_ok    = char_in_range(char_sync);
    end

    // ------------------------------------------------------------------
    // Optional auto-repeat
    // ------------------------------------------------------------------
`ifdef ENIGMA_AUTO_REPEAT_EN
    logic [31:0] rpt_cnt;
    logic        rpt_first;
    logic [31:0] rpt_last;

    assign rpt_last = rpt_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
    assign rpt_hit  = (state == HELD) && (rpt_cnt == rpt_last);

    // Time the hold: first tick after REPEAT_DELAY, then every REPEAT_PERIOD; idle outside HELD.
    always_ff @(posedge CLOCK_50) begin
        if (reset || state != HELD) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_cnt != '1) begin
            rpt_cnt   <= rpt_cnt + 32'd1;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------

    // Register strobes and the captured character; an out-of-range code flags an error and leaves char_out alone.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            char_pressed <= 1'b0;
            char_error   <= 1'b0;
            char_out     <= '0;
            key_held     <= 1'b0;
        end else begin
            char_pressed <= fire && sample_ok;
            char_error   <= fire && !sample_ok;
            if (fire && sample_ok) begin
                char_out <= char_sync;
            end
            key_held     <= deb_pressed;
        end
    end

endmodule
